// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock over WIDTH cycles,
// sharing the start/ready handshake of the shift-and-add multiplier.
`timescale 1ns/1ps
module restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             busy,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             divide_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, WORKING, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] m_reg;
  logic [CW-1:0]    counter;
  logic             dbz;

  logic [WIDTH:0]   a_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] q_shift;

  // The stored partial remainder is always < M, so only the shifted value needs the extra bit.
  always_comb begin
    a_shift = {a_reg, q_reg[WIDTH-1]};
    q_shift = {q_reg[WIDTH-2:0], 1'b0};
    trial   = a_shift - {1'b0, m_reg};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      a_reg   <= '0;
      q_reg   <= '0;
      m_reg   <= '0;
      counter <= '0;
      dbz     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (divisor == '0) begin
              a_reg <= dividend;
              q_reg <= '1;
              dbz   <= 1'b1;
              state <= DONE;
            end else begin
              a_reg   <= '0;
              q_reg   <= dividend;
              m_reg   <= divisor;
              counter <= CW'(WIDTH - 1);
              dbz     <= 1'b0;
              state   <= WORKING;
            end
          end
        end
        WORKING: begin
          if (!trial[WIDTH]) begin
            a_reg <= trial[WIDTH-1:0];
            q_reg <= {q_shift[WIDTH-1:1], 1'b1};
          end else begin
            a_reg <= a_shift[WIDTH-1:0];
            q_reg <= q_shift;
          end
          if (counter == '0) begin
            state <= DONE;
          end else begin
            counter <= counter - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready          = (state == DONE);
  assign busy           = (state == WORKING);
  assign quotient       = q_reg;
  assign remainder      = a_reg;
  assign divide_by_zero = dbz;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed bench for restoring_divider at WIDTH=8 and WIDTH=16; inputs driven and outputs sampled on falling edges.
`timescale 1ns/1ps
module tb_restoring_divider;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;

  logic        start8 = 1'b0;
  logic [7:0]  dividend8 = '0, divisor8 = '0;
  logic        ready8, busy8, dbz8;
  logic [7:0]  quotient8, remainder8;

  logic        start16 = 1'b0;
  logic [15:0] dividend16 = '0, divisor16 = '0;
  logic        ready16, busy16, dbz16;
  logic [15:0] quotient16, remainder16;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  restoring_divider #(.WIDTH(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .start(start8),
    .dividend(dividend8), .divisor(divisor8),
    .ready(ready8), .busy(busy8), .quotient(quotient8),
    .remainder(remainder8), .divide_by_zero(dbz8)
  );

  restoring_divider #(.WIDTH(16)) dut16 (
    .clock(clock), .reset_n(reset_n), .start(start16),
    .dividend(dividend16), .divisor(divisor16),
    .ready(ready16), .busy(busy16), .quotient(quotient16),
    .remainder(remainder16), .divide_by_zero(dbz16)
  );

  // Pulse start for one edge; returns at the falling edge just after the accepting edge (cycle 0).
  task automatic pulse8(input logic [7:0] dd, input logic [7:0] dv);
    @(negedge clock);
    dividend8 = dd; divisor8 = dv; start8 = 1'b1;
    @(negedge clock);
    start8 = 1'b0;
  endtask

  task automatic pulse16(input logic [15:0] dd, input logic [15:0] dv);
    @(negedge clock);
    dividend16 = dd; divisor16 = dv; start16 = 1'b1;
    @(negedge clock);
    start16 = 1'b0;
  endtask

  task automatic wait_ready8(output int cycles);
    cycles = 0;
    while (!ready8 && cycles < 40) begin
      @(negedge clock);
      cycles++;
    end
  endtask

  task automatic wait_ready16(output int cycles);
    cycles = 0;
    while (!ready16 && cycles < 60) begin
      @(negedge clock);
      cycles++;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (ready8 !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready8 got %b want 0", ready8); end
    checks++; if (busy8 !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy8 got %b want 0", busy8); end
    checks++; if (quotient8 !== 8'd0) begin failures++; $display("[TB] FAIL reset_quotient8 got %0d want 0", quotient8); end
    checks++; if (remainder8 !== 8'd0) begin failures++; $display("[TB] FAIL reset_remainder8 got %0d want 0", remainder8); end
    checks++; if (dbz8 !== 1'b0) begin failures++; $display("[TB] FAIL reset_dbz8 got %b want 0", dbz8); end
    checks++; if (ready16 !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready16 got %b want 0", ready16); end
    checks++; if (busy16 !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy16 got %b want 0", busy16); end
    checks++; if (quotient16 !== 16'd0) begin failures++; $display("[TB] FAIL reset_quotient16 got %0d want 0", quotient16); end
    reset_n = 1'b1;
  endtask

  task automatic test_basic;
    int cycles;
    pulse8(8'd100, 8'd7);
    cycles = 0;
    while (cycles < 8) begin
      checks++; if (busy8 !== 1'b1 || ready8 !== 1'b0) begin
        failures++; $display("[TB] FAIL basic_busy cycle %0d got busy=%b ready=%b want busy=1 ready=0", cycles, busy8, ready8);
      end
      @(negedge clock);
      cycles++;
    end
    checks++; if (ready8 !== 1'b1 || busy8 !== 1'b0) begin failures++; $display("[TB] FAIL basic_ready_at_8 got ready=%b busy=%b want ready=1 busy=0", ready8, busy8); end
    checks++; if (quotient8 !== 8'd14) begin failures++; $display("[TB] FAIL basic_quotient got %0d want 14", quotient8); end
    checks++; if (remainder8 !== 8'd2) begin failures++; $display("[TB] FAIL basic_remainder got %0d want 2", remainder8); end
    checks++; if (dbz8 !== 1'b0) begin failures++; $display("[TB] FAIL basic_dbz got %b want 0", dbz8); end
    @(negedge clock);
    checks++; if (ready8 !== 1'b1 || quotient8 !== 8'd14) begin failures++; $display("[TB] FAIL basic_hold got ready=%b q=%0d want ready=1 q=14", ready8, quotient8); end
  endtask

  task automatic test_corners;
    logic [7:0] dd_tab [4] = '{8'd255, 8'd5, 8'd255, 8'd0};
    logic [7:0] dv_tab [4] = '{8'd1,   8'd9, 8'd255, 8'd3};
    logic [7:0] q_tab  [4] = '{8'd255, 8'd0, 8'd1,   8'd0};
    logic [7:0] r_tab  [4] = '{8'd0,   8'd5, 8'd0,   8'd0};
    int cycles;
    for (int i = 0; i < 4; i++) begin
      pulse8(dd_tab[i], dv_tab[i]);
      wait_ready8(cycles);
      checks++; if (cycles != 8) begin failures++; $display("[TB] FAIL corner%0d_latency got %0d want 8", i, cycles); end
      checks++; if (quotient8 !== q_tab[i]) begin failures++; $display("[TB] FAIL corner%0d_quotient got %0d want %0d", i, quotient8, q_tab[i]); end
      checks++; if (remainder8 !== r_tab[i]) begin failures++; $display("[TB] FAIL corner%0d_remainder got %0d want %0d", i, remainder8, r_tab[i]); end
    end
  endtask

  task automatic test_divide_by_zero;
    int cycles;
    pulse8(8'd42, 8'd0);
    checks++; if (ready8 !== 1'b1 || dbz8 !== 1'b1 || busy8 !== 1'b0) begin
      failures++; $display("[TB] FAIL dbz_flags got ready=%b dbz=%b busy=%b want 1 1 0", ready8, dbz8, busy8);
    end
    checks++; if (quotient8 !== 8'd255) begin failures++; $display("[TB] FAIL dbz_quotient got %0d want 255", quotient8); end
    checks++; if (remainder8 !== 8'd42) begin failures++; $display("[TB] FAIL dbz_remainder got %0d want 42", remainder8); end
    pulse8(8'd42, 8'd6);
    checks++; if (dbz8 !== 1'b0 || ready8 !== 1'b0 || busy8 !== 1'b1) begin
      failures++; $display("[TB] FAIL dbz_restart got dbz=%b ready=%b busy=%b want 0 0 1", dbz8, ready8, busy8);
    end
    wait_ready8(cycles);
    checks++; if (cycles != 8) begin failures++; $display("[TB] FAIL dbz_after_latency got %0d want 8", cycles); end
    checks++; if (quotient8 !== 8'd7 || remainder8 !== 8'd0) begin
      failures++; $display("[TB] FAIL dbz_after_result got q=%0d r=%0d want q=7 r=0", quotient8, remainder8);
    end
  endtask

  task automatic test_ignore_start;
    int cycles;
    pulse8(8'd100, 8'd7);
    repeat (2) @(negedge clock);
    dividend8 = 8'd50; divisor8 = 8'd5; start8 = 1'b1;
    @(negedge clock);
    start8 = 1'b0;
    wait_ready8(cycles);
    checks++; if (cycles != 5) begin failures++; $display("[TB] FAIL ignore_latency got %0d want 5 more cycles", cycles); end
    checks++; if (quotient8 !== 8'd14 || remainder8 !== 8'd2) begin
      failures++; $display("[TB] FAIL ignore_result got q=%0d r=%0d want q=14 r=2", quotient8, remainder8);
    end
  endtask

  task automatic test_reset_mid;
    int cycles;
    pulse8(8'd100, 8'd7);
    repeat (4) @(negedge clock);
    reset_n = 1'b0;
    #1;
    checks++; if (busy8 !== 1'b0 || ready8 !== 1'b0 || dbz8 !== 1'b0) begin
      failures++; $display("[TB] FAIL midreset_flags got busy=%b ready=%b dbz=%b want 0 0 0", busy8, ready8, dbz8);
    end
    checks++; if (quotient8 !== 8'd0 || remainder8 !== 8'd0) begin
      failures++; $display("[TB] FAIL midreset_data got q=%0d r=%0d want 0 0", quotient8, remainder8);
    end
    @(negedge clock);
    reset_n = 1'b1;
    pulse8(8'd200, 8'd13);
    wait_ready8(cycles);
    checks++; if (cycles != 8) begin failures++; $display("[TB] FAIL midreset_latency got %0d want 8", cycles); end
    checks++; if (quotient8 !== 8'd15 || remainder8 !== 8'd5) begin
      failures++; $display("[TB] FAIL midreset_result got q=%0d r=%0d want q=15 r=5", quotient8, remainder8);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    @(negedge clock);
    dividend8 = 8'd100; divisor8 = 8'd7; start8 = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (!ready8 && n < 40);
    checks++; if (n != 9 || quotient8 !== 8'd14 || remainder8 !== 8'd2) begin
      failures++; $display("[TB] FAIL b2b_first got n=%0d q=%0d r=%0d want n=9 q=14 r=2", n, quotient8, remainder8);
    end
    dividend8 = 8'd255; divisor8 = 8'd16;
    n = 0;
    do begin @(negedge clock); n++; end while (!ready8 && n < 40);
    start8 = 1'b0;
    checks++; if (n != 9) begin failures++; $display("[TB] FAIL b2b_throughput got %0d want 9", n); end
    checks++; if (quotient8 !== 8'd15 || remainder8 !== 8'd15) begin
      failures++; $display("[TB] FAIL b2b_second got q=%0d r=%0d want q=15 r=15", quotient8, remainder8);
    end
  endtask

  task automatic test_sweep;
    int cycles;
    logic [7:0]  dd8, dv8;
    logic [15:0] dd16, dv16;
    for (int i = 0; i < 200; i++) begin
      dd8 = 8'($urandom_range(0, 255));
      dv8 = 8'($urandom_range(1, 255));
      pulse8(dd8, dv8);
      wait_ready8(cycles);
      checks++; if (cycles != 8 || quotient8 !== dd8 / dv8 || remainder8 !== dd8 % dv8) begin
        failures++; $display("[TB] FAIL sweep8 %0d/%0d got q=%0d r=%0d lat=%0d want q=%0d r=%0d lat=8",
                             dd8, dv8, quotient8, remainder8, cycles, dd8 / dv8, dd8 % dv8);
      end
    end
    for (int i = 0; i < 100; i++) begin
      dd16 = 16'($urandom_range(0, 65535));
      dv16 = (i % 2 == 0) ? 16'($urandom_range(1, 255)) : 16'($urandom_range(1, 65535));
      pulse16(dd16, dv16);
      wait_ready16(cycles);
      checks++; if (cycles != 16 || quotient16 !== dd16 / dv16 || remainder16 !== dd16 % dv16) begin
        failures++; $display("[TB] FAIL sweep16 %0d/%0d got q=%0d r=%0d lat=%0d want q=%0d r=%0d lat=16",
                             dd16, dv16, quotient16, remainder16, cycles, dd16 / dv16, dd16 % dv16);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_divide_by_zero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
